// File: rtl/ili9341_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ili9341_sequencer_pkg
//  Description : Shared constants and types for the ILI9341 display sequencer:
//                logic levels, command-array select codes, default panel
//                geometry and the sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ili9341_sequencer_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Command-array select driven to the sender
  localparam logic INI_COMMS  = 1'b0;
  localparam logic LOOP_COMMS = 1'b1;

  // Default panel geometry (portrait 240x320)
  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HWRST     = 3'd1,
    HWWAIT    = 3'd2,
    INIT      = 3'd3,
    SETTLE    = 3'd4,
    WINDOW    = 3'd5,
    PIXELS    = 3'd6,
    FRAME_END = 3'd7
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ili9341_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ili9341_sequencer_if
//  Description : Handshake bundle between the sequencer and the command-array
//                sender / pixel byte streamer.
//                  cmd_ena  : one-cycle start pulse for the command sender
//                  cmd_sel  : INI_COMMS / LOOP_COMMS array select
//                  cmd_done : one-cycle pulse, array fully sent
//                  pix_ena  : level, pixel streamer may transmit
//                  pix_sent : one-cycle pulse per pixel byte sent on SPI
//  Revision    : 1.0  initial release
// ============================================================================
interface ili9341_sequencer_if;

  logic cmd_ena;
  logic cmd_sel;
  logic cmd_done;
  logic pix_ena;
  logic pix_sent;

  // Sequencer side
  modport master (
    output cmd_ena,
    output cmd_sel,
    output pix_ena,
    input  cmd_done,
    input  pix_sent
  );

  // Sender / streamer side
  modport slave (
    input  cmd_ena,
    input  cmd_sel,
    input  pix_ena,
    output cmd_done,
    output pix_sent
  );

endinterface
`default_nettype wire

// File: rtl/ili9341_sequencer_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sequencer_delay
//  Description : Down-counting delay timer shared by the fixed-length states.
//                Load N-1 on state entry; o_expired is high in the N-th cycle.
//  Ports       : clk, rst        clock / sync active-high reset
//                i_load          load i_load_val (takes priority)
//                i_load_val      terminal count minus one
//                i_en            count down while nonzero
//                o_expired       count has reached zero
//  Revision    : 1.0  initial release
// ============================================================================
module sequencer_delay #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  input  wire logic             i_en,
  output logic                  o_expired
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ili9341_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ili9341_sequencer
//  Description : Power-up and frame sequencer for the ILI9341 SPI display.
//                Hardware reset pulse -> post-reset wait -> init array ->
//                settle -> repeat { window array, one frame of pixel bytes }.
//  Ports       : clk, rst        clock / sync active-high reset
//                i_start         start power-up from IDLE
//                i_stop          halt request, honoured at a frame boundary
//                bus (master)    command sender / pixel streamer handshake
//                o_lcd_rst_n     display hardware reset, active-low
//                o_frame_done    one-cycle pulse after the last frame byte
//                o_init_done     init sequence complete
//                o_busy          any state other than IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module ili9341_sequencer
  import ili9341_sequencer_pkg::*;
#(
  parameter int RST_CYC   = 1000,
  parameter int RST_WAIT  = 12000000,
  parameter int INIT_WAIT = 12000000,
  parameter int H_RES     = H_RES_DEF,
  parameter int V_RES     = V_RES_DEF,
  parameter int BPP_BYTES = 2
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_start,
  input  wire logic               i_stop,
  ili9341_sequencer_if.master     bus,
  output logic                    o_lcd_rst_n,
  output logic                    o_frame_done,
  output logic                    o_init_done,
  output logic                    o_busy
);

  localparam int c_TOTAL   = H_RES * V_RES * BPP_BYTES;
  localparam int c_BW      = $clog2(c_TOTAL + 1);
  localparam int c_DLY_MAX = (RST_CYC > RST_WAIT)
                             ? ((RST_CYC > INIT_WAIT) ? RST_CYC : INIT_WAIT)
                             : ((RST_WAIT > INIT_WAIT) ? RST_WAIT : INIT_WAIT);
  localparam int c_DW      = $clog2(c_DLY_MAX + 1);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic              w_entry;
  logic [c_BW-1:0]   r_bytes;
  logic              r_stop;

  logic              r_cmd_ena;
  logic              r_cmd_sel;
  logic              r_pix_ena;

  logic              w_dly_load;
  logic              w_dly_en;
  logic [c_DW-1:0]   w_dly_val;
  logic              w_dly_expired;

  // --------------------------------------------------------------------------
  // Delay timer for HWRST / HWWAIT / SETTLE
  // --------------------------------------------------------------------------
  sequencer_delay #(
    .WIDTH (c_DW)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_dly_load),
    .i_load_val (w_dly_val),
    .i_en       (w_dly_en),
    .o_expired  (w_dly_expired)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_dly_load = 1'b0;
    w_dly_val  = '0;
    w_dly_en   = 1'b0;

    case (r_state)
      IDLE:      if (i_start)       w_next = HWRST;
      HWRST:     if (w_dly_expired) w_next = HWWAIT;
      HWWAIT:    if (w_dly_expired) w_next = INIT;
      INIT:      if (bus.cmd_done)  w_next = SETTLE;
      SETTLE:    if (w_dly_expired) w_next = WINDOW;
      WINDOW:    if (bus.cmd_done)  w_next = PIXELS;
      // Leave on the pulse that consumes the final byte
      PIXELS:    if (bus.pix_sent && (r_bytes == c_BW'(1))) w_next = FRAME_END;
      // A stop arriving in this very cycle still counts at this boundary
      FRAME_END: w_next = (r_stop || i_stop) ? IDLE : WINDOW;
      default:   w_next = IDLE;
    endcase

    w_entry = (w_next != r_state);

    // Delay states load N-1 on entry so they last exactly N cycles
    case (w_next)
      HWRST:   w_dly_val = c_DW'(RST_CYC - 1);
      HWWAIT:  w_dly_val = c_DW'(RST_WAIT - 1);
      SETTLE:  w_dly_val = c_DW'(INIT_WAIT - 1);
      default: w_dly_val = '0;
    endcase
    w_dly_load = w_entry && ((w_next == HWRST) || (w_next == HWWAIT) || (w_next == SETTLE));
    w_dly_en   = (r_state == HWRST) || (r_state == HWWAIT) || (r_state == SETTLE);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, byte counter and stop latch. Outputs are derived from
  // the state being entered so they line up with the state register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_lcd_rst_n  <= HIGH;
      r_cmd_ena    <= LOW;
      r_cmd_sel    <= INI_COMMS;
      r_pix_ena    <= LOW;
      o_frame_done <= LOW;
      o_init_done  <= LOW;
      o_busy       <= LOW;
      r_bytes      <= '0;
      r_stop       <= LOW;
    end else begin
      o_lcd_rst_n  <= (w_next != HWRST);
      r_cmd_ena    <= w_entry && ((w_next == INIT) || (w_next == WINDOW));
      r_cmd_sel    <= ((w_next == WINDOW) || (w_next == PIXELS) || (w_next == FRAME_END))
                      ? LOOP_COMMS : INI_COMMS;
      r_pix_ena    <= (w_next == PIXELS);
      o_frame_done <= (w_next == FRAME_END);
      o_busy       <= (w_next != IDLE);

      if (w_next == IDLE) begin
        o_init_done <= LOW;
      end else if ((r_state == SETTLE) && (w_next == WINDOW)) begin
        o_init_done <= HIGH;
      end

      if (w_next == IDLE) begin
        r_stop <= LOW;
      end else if (i_stop && (r_state != IDLE)) begin
        r_stop <= HIGH;
      end

      if (w_entry && (w_next == PIXELS)) begin
        r_bytes <= c_BW'(c_TOTAL);
      end else if ((r_state == PIXELS) && bus.pix_sent) begin
        r_bytes <= r_bytes - 1'b1;
      end
    end
  end

  assign bus.cmd_ena = r_cmd_ena;
  assign bus.cmd_sel = r_cmd_sel;
  assign bus.pix_ena = r_pix_ena;

endmodule
`default_nettype wire

// File: tb/tb_ili9341_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ili9341_sequencer
//  Description : Self-checking bench for ili9341_sequencer. A phase/elapsed-
//                time model predicts every output each cycle; a directed
//                scenario is followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ili9341_sequencer;
  import ili9341_sequencer_pkg::*;

  localparam int c_RST_CYC   = 4;
  localparam int c_RST_WAIT  = 6;
  localparam int c_INIT_WAIT = 5;
  localparam int c_H_RES     = 2;
  localparam int c_V_RES     = 2;
  localparam int c_BPP       = 2;
  localparam int c_TOTAL     = c_H_RES * c_V_RES * c_BPP;

  // Model phases
  localparam int P_IDLE = 0, P_HWRST = 1, P_HWWAIT = 2, P_INIT = 3,
                 P_SETTLE = 4, P_WINDOW = 5, P_PIXELS = 6, P_FEND = 7;

  logic clk = 1'b0;
  logic rst, start, stop, cmd_done, pix_sent;
  logic lcd_rst_n, frame_done, init_done, busy;

  int n_checks = 0;
  int n_errors = 0;

  ili9341_sequencer_if bus ();
  assign bus.cmd_done = cmd_done;
  assign bus.pix_sent = pix_sent;

  ili9341_sequencer #(
    .RST_CYC   (c_RST_CYC),
    .RST_WAIT  (c_RST_WAIT),
    .INIT_WAIT (c_INIT_WAIT),
    .H_RES     (c_H_RES),
    .V_RES     (c_V_RES),
    .BPP_BYTES (c_BPP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_stop       (stop),
    .bus          (bus),
    .o_lcd_rst_n  (lcd_rst_n),
    .o_frame_done (frame_done),
    .o_init_done  (init_done),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: current phase, cycles spent in it, bytes sent this frame
  // --------------------------------------------------------------------------
  int ph = P_IDLE, el = 0, sent = 0;
  bit stop_req = 0, m_init = 0;

  always @(posedge clk) begin
    int nph;
    if (rst) begin
      ph = P_IDLE; el = 0; sent = 0; stop_req = 0; m_init = 0;
    end else begin
      nph = ph;
      if (stop && ph != P_IDLE) stop_req = 1;
      case (ph)
        P_IDLE:   if (start) nph = P_HWRST;
        P_HWRST:  if (el + 1 == c_RST_CYC) nph = P_HWWAIT;
        P_HWWAIT: if (el + 1 == c_RST_WAIT) nph = P_INIT;
        P_INIT:   if (cmd_done) nph = P_SETTLE;
        P_SETTLE: if (el + 1 == c_INIT_WAIT) begin nph = P_WINDOW; m_init = 1; end
        P_WINDOW: if (cmd_done) begin nph = P_PIXELS; sent = 0; end
        P_PIXELS: if (pix_sent) begin
                    sent++;
                    if (sent == c_TOTAL) nph = P_FEND;
                  end
        P_FEND:   nph = stop_req ? P_IDLE : P_WINDOW;
        default:  nph = P_IDLE;
      endcase
      if (nph == P_IDLE && ph != P_IDLE) begin
        stop_req = 0; m_init = 0;
      end
      el = (nph == ph) ? el + 1 : 0;
      ph = nph;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: observed %0h expected %0h (phase %0d)", tag, $time, obs, exp, ph);
    end
  endtask

  // Compare every output against the model, then drive the next inputs
  task automatic step(input bit s, input bit st, input bit cd, input bit ps, input bit r);
    @(negedge clk);
    check("lcd_rst_n",  32'(lcd_rst_n),   32'(ph != P_HWRST));
    check("cmd_ena",    32'(bus.cmd_ena), 32'((ph == P_INIT || ph == P_WINDOW) && el == 0));
    check("cmd_sel",    32'(bus.cmd_sel),
          32'((ph == P_WINDOW || ph == P_PIXELS || ph == P_FEND) ? LOOP_COMMS : INI_COMMS));
    check("pix_ena",    32'(bus.pix_ena), 32'(ph == P_PIXELS));
    check("frame_done", 32'(frame_done),  32'(ph == P_FEND));
    check("init_done",  32'(init_done),   32'(m_init));
    check("busy",       32'(busy),        32'(ph != P_IDLE));
    start = s; stop = st; cmd_done = cd; pix_sent = ps; rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; cmd_done = 0; pix_sent = 0;

    // Reset, then power-up with a stray cmd_done in HWWAIT and start while busy
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(6);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(5);
    step(0, 0, 1, 0, 0);          // INIT done -> settle
    idle(7);
    step(0, 0, 1, 0, 0);          // WINDOW done -> pixels
    for (int i = 0; i < c_TOTAL; i++) begin
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0);        // stray cmd_done inside PIXELS
    end
    step(0, 0, 0, 1, 0);          // stray 9th byte
    idle(2);
    step(0, 0, 1, 0, 0);          // next window
    for (int i = 0; i < c_TOTAL; i++) begin
      step(0, (i == 3), 0, 1, 0); // stop mid-frame
      idle(1);
    end
    idle(4);

    // Restart, abort with rst after three bytes, then restart again
    step(1, 0, 0, 0, 0);
    idle(11);
    step(0, 0, 1, 0, 0);
    idle(7);
    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(11);
    step(0, 0, 1, 0, 0);
    idle(7);
    step(0, 0, 1, 0, 0);
    repeat (c_TOTAL) step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);          // stop in the same cycle as FRAME_END
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      step(($urandom_range(0, 7) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 499) == 0));
    end
    idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
